// File: rtl/password_lock_ctrl.sv
// rtl/password_lock_ctrl.sv - keypad password lock: entry buffer, stored password, attempt counter, timed lockout
module password_lock_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int PW_LEN      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             set_pw,
    input  logic                             test,
    input  logic                             lock,
    input  logic                             clear,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    output logic [2:0]                       state,
    output logic                             pw_set,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic                             pass_ok,
    output logic                             pass_fail,
    output logic                             entry_err,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic [$clog2(PW_LEN+1)-1:0]      digit_cnt
);

    localparam int BUF_W = PW_LEN * DIGIT_W;
    localparam int DC_W  = $clog2(PW_LEN + 1);
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int LC_W  = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [DC_W-1:0] FULL_CNT  = DC_W'(PW_LEN);
    localparam logic [TW-1:0]   TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [TW-1:0]   TRIES_ONE = TW'(1);
    localparam logic [LC_W-1:0] LOCK_LOAD = (LOCK_CYCLES > 0) ? LC_W'(LOCK_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        NO_PW      = 3'd0,
        SET_ENTRY  = 3'd1,
        READY      = 3'd2,
        TEST_ENTRY = 3'd3,
        CHECK      = 3'd4,
        UNLOCKED   = 3'd5,
        LOCKOUT    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [BUF_W-1:0]  stored_q, stored_d;
    logic [DC_W-1:0]   cnt_d;
    logic [TW-1:0]     tries_d;
    logic [LC_W-1:0]   lock_q, lock_d;
    logic              pw_set_d, ok_d, fail_d, err_d;
    logic              match;

    assign state = state_q;
    assign match = (digit_cnt == FULL_CNT) && (buf_q == stored_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NO_PW;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            stored_q   <= '0;
            digit_cnt  <= '0;
            tries_left <= TRIES_MAX;
            lock_q     <= '0;
            pw_set     <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            pass_ok    <= 1'b0;
            pass_fail  <= 1'b0;
            entry_err  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            stored_q   <= stored_d;
            digit_cnt  <= cnt_d;
            tries_left <= tries_d;
            lock_q     <= lock_d;
            pw_set     <= pw_set_d;
            unlocked   <= (state_d == UNLOCKED);
            locked_out <= (state_d == LOCKOUT);
            pass_ok    <= ok_d;
            pass_fail  <= fail_d;
            entry_err  <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = digit_cnt;
        stored_d = stored_q;
        tries_d  = tries_left;
        lock_d   = lock_q;
        pw_set_d = pw_set;
        ok_d     = 1'b0;
        fail_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            NO_PW: begin
                if (set_pw) begin
                    state_d = SET_ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end

            SET_ENTRY, TEST_ENTRY: begin
                if (clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (enter) begin
                    if (state_q == TEST_ENTRY) begin
                        // buffer is held through CHECK for the comparator
                        state_d = CHECK;
                    end else if (digit_cnt == FULL_CNT) begin
                        stored_d = buf_q;
                        pw_set_d = 1'b1;
                        tries_d  = TRIES_MAX;
                        state_d  = READY;
                        buf_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        err_d = 1'b1;
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (digit_valid && (digit_cnt < FULL_CNT)) begin
                    buf_d = (buf_q << DIGIT_W) | BUF_W'(digit);
                    cnt_d = digit_cnt + 1'b1;
                end
            end

            READY: begin
                if (test) begin
                    state_d = TEST_ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end

            CHECK: begin
                buf_d  = '0;
                cnt_d  = '0;
                if (match) begin
                    ok_d    = 1'b1;
                    tries_d = TRIES_MAX;
                    state_d = UNLOCKED;
                end else if (tries_left > TRIES_ONE) begin
                    fail_d  = 1'b1;
                    tries_d = tries_left - 1'b1;
                    state_d = READY;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = '0;
                    lock_d  = LOCK_LOAD;
                    state_d = LOCKOUT;
                end
            end

            UNLOCKED: begin
                if (set_pw) begin
                    state_d = SET_ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (lock) begin
                    state_d = READY;
                end
            end

            LOCKOUT: begin
                // a zero duration means the lock only opens through rst
                if (LOCK_CYCLES != 0) begin
                    if (lock_q == '0) begin
                        state_d = READY;
                        tries_d = TRIES_MAX;
                    end else begin
                        lock_d = lock_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = NO_PW;
            end
        endcase
    end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// tb/tb_password_lock_ctrl.sv - table-driven bench for password_lock_ctrl
module tb_password_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_pw = 1'b0, test = 1'b0, lock = 1'b0, clear = 1'b0;
    logic       digit_valid = 1'b0, enter = 1'b0;
    logic [3:0] digit = 4'd0;

    logic [2:0] state, state_z;
    logic       pw_set, unlocked, locked_out, pass_ok, pass_fail, entry_err;
    logic       pw_set_z, unlocked_z, locked_out_z, pass_ok_z, pass_fail_z, entry_err_z;
    logic [1:0] tries_left, tries_left_z;
    logic [2:0] digit_cnt, digit_cnt_z;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    password_lock_ctrl #(.DIGIT_W(4), .PW_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .set_pw(set_pw), .test(test), .lock(lock), .clear(clear),
        .digit_valid(digit_valid), .digit(digit), .enter(enter),
        .state(state), .pw_set(pw_set), .unlocked(unlocked), .locked_out(locked_out),
        .pass_ok(pass_ok), .pass_fail(pass_fail), .entry_err(entry_err),
        .tries_left(tries_left), .digit_cnt(digit_cnt)
    );

    password_lock_ctrl #(.DIGIT_W(4), .PW_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(0)) dut_perm (
        .clk(clk), .rst(rst), .set_pw(set_pw), .test(test), .lock(lock), .clear(clear),
        .digit_valid(digit_valid), .digit(digit), .enter(enter),
        .state(state_z), .pw_set(pw_set_z), .unlocked(unlocked_z), .locked_out(locked_out_z),
        .pass_ok(pass_ok_z), .pass_fail(pass_fail_z), .entry_err(entry_err_z),
        .tries_left(tries_left_z), .digit_cnt(digit_cnt_z)
    );

    // cmd bits: {set_pw, test, lock, clear, digit_valid, enter}
    localparam logic [5:0] N = 6'b000000, S = 6'b100000, T = 6'b010000, L = 6'b001000;
    localparam logic [5:0] C = 6'b000100, D = 6'b000010, E = 6'b000001;
    // flag bits: {pw_set, unlocked, locked_out, pass_ok, pass_fail, entry_err}
    localparam logic [5:0] F_PW = 6'b100000, F_UN = 6'b010000, F_LO = 6'b001000;
    localparam logic [5:0] F_OK = 6'b000100, F_FAIL = 6'b000010, F_ERR = 6'b000001;

    typedef struct {
        string      name;
        logic [5:0] cmd;
        logic [3:0] dig;
        logic [2:0] st;
        logic [2:0] cnt;
        logic [1:0] tries;
        logic [5:0] flags;
    } vec_t;

    vec_t vecs[$];
    int   split;

    task automatic add(input string nm, input logic [5:0] cmd, input logic [3:0] dg,
                       input logic [2:0] st, input logic [2:0] cnt, input logic [1:0] tr,
                       input logic [5:0] fl);
        vec_t v;
        v.name = nm; v.cmd = cmd; v.dig = dg; v.st = st; v.cnt = cnt; v.tries = tr; v.flags = fl;
        vecs.push_back(v);
    endtask

    task automatic add_digits(input string nm, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3, input logic [2:0] st,
                              input logic [1:0] tr, input logic [5:0] fl);
        add({nm, "_d1"}, D, d0, st, 3'd1, tr, fl);
        add({nm, "_d2"}, D, d1, st, 3'd2, tr, fl);
        add({nm, "_d3"}, D, d2, st, 3'd3, tr, fl);
        add({nm, "_d4"}, D, d3, st, 3'd4, tr, fl);
    endtask

    task automatic add_try(input string nm, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3, input logic [1:0] tb,
                           input logic [1:0] ta, input bit lk);
        add({nm, "_test"}, T, 4'd0, 3'd3, 3'd0, tb, F_PW);
        add_digits(nm, d0, d1, d2, d3, 3'd3, tb, F_PW);
        add({nm, "_enter"}, E, 4'd0, 3'd4, 3'd4, tb, F_PW);
        add({nm, "_result"}, N, 4'd0, lk ? 3'd6 : 3'd2, 3'd0, ta,
            F_PW | F_FAIL | (lk ? F_LO : 6'b0));
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [5:0] flags_now();
        return {pw_set, unlocked, locked_out, pass_ok, pass_fail, entry_err};
    endfunction

    task automatic drive(input logic [5:0] cmd, input logic [3:0] dg);
        {set_pw, test, lock, clear, digit_valid, enter} = cmd;
        digit = dg;
        @(posedge clk);
        #1;
        {set_pw, test, lock, clear, digit_valid, enter} = 6'b0;
    endtask

    task automatic apply(input vec_t v);
        drive(v.cmd, v.dig);
        chk({v.name, ".state"}, state, v.st);
        chk({v.name, ".digit_cnt"}, digit_cnt, v.cnt);
        chk({v.name, ".tries_left"}, tries_left, v.tries);
        chk({v.name, ".flags"}, flags_now(), v.flags);
    endtask

    initial begin
        int lo_cycles;

        // password definition, saturating entry, unlock, three failures into lockout
        add("nopw_digit", D, 4'd5, 3'd0, 3'd0, 2'd3, 6'b0);
        add("nopw_enter", E, 4'd0, 3'd0, 3'd0, 2'd3, 6'b0);
        add("nopw_test",  T, 4'd0, 3'd0, 3'd0, 2'd3, 6'b0);
        add("set",        S, 4'd0, 3'd1, 3'd0, 2'd3, 6'b0);
        add("short_d1",   D, 4'd1, 3'd1, 3'd1, 2'd3, 6'b0);
        add("short_d2",   D, 4'd2, 3'd1, 3'd2, 2'd3, 6'b0);
        add("short_ent",  E, 4'd0, 3'd1, 3'd0, 2'd3, F_ERR);
        add("err_gone",   N, 4'd0, 3'd1, 3'd0, 2'd3, 6'b0);
        add_digits("set", 4'd1, 4'd2, 4'd3, 4'd4, 3'd1, 2'd3, 6'b0);
        add("set_ent",    E, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add("rdy_setpw",  S, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add("test",       T, 4'd0, 3'd3, 3'd0, 2'd3, F_PW);
        add_digits("t",   4'd1, 4'd2, 4'd3, 4'd4, 3'd3, 2'd3, F_PW);
        add("t_d5_sat",   D, 4'd5, 3'd3, 3'd4, 2'd3, F_PW);
        add("t_enter",    E, 4'd0, 3'd4, 3'd4, 2'd3, F_PW);
        add("unlock",     N, 4'd0, 3'd5, 3'd0, 2'd3, F_PW | F_UN | F_OK);
        add("unl_hold",   N, 4'd0, 3'd5, 3'd0, 2'd3, F_PW | F_UN);
        add("relock",     L, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add_try("w1", 4'd1, 4'd2, 4'd3, 4'd5, 2'd3, 2'd2, 1'b0);
        add_try("w2", 4'd1, 4'd2, 4'd3, 4'd5, 2'd2, 2'd1, 1'b0);
        add_try("w3", 4'd1, 4'd2, 4'd3, 4'd5, 2'd1, 2'd0, 1'b1);
        split = vecs.size();

        // password change from UNLOCKED, clear, same-cycle priorities, second lockout
        add("b_test",     T, 4'd0, 3'd3, 3'd0, 2'd3, F_PW);
        add_digits("b",   4'd1, 4'd2, 4'd3, 4'd4, 3'd3, 2'd3, F_PW);
        add("b_enter",    E, 4'd0, 3'd4, 3'd4, 2'd3, F_PW);
        add("b_unlock",   N, 4'd0, 3'd5, 3'd0, 2'd3, F_PW | F_UN | F_OK);
        add("chg_set",    S, 4'd0, 3'd1, 3'd0, 2'd3, F_PW);
        add_digits("chg", 4'd9, 4'd8, 4'd7, 4'd6, 3'd1, 2'd3, F_PW);
        add("chg_ent",    E, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add("rdy_lock",   L, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add_try("old_pw", 4'd1, 4'd2, 4'd3, 4'd4, 2'd3, 2'd2, 1'b0);
        add("c_test",     T, 4'd0, 3'd3, 3'd0, 2'd2, F_PW);
        add("c_d9",       D, 4'd9, 3'd3, 3'd1, 2'd2, F_PW);
        add("c_d8",       D, 4'd8, 3'd3, 3'd2, 2'd2, F_PW);
        add("c_clear",    C, 4'd0, 3'd3, 3'd0, 2'd2, F_PW);
        add_digits("c",   4'd9, 4'd8, 4'd7, 4'd6, 3'd3, 2'd2, F_PW);
        add("c_enter",    E, 4'd0, 3'd4, 3'd4, 2'd2, F_PW);
        add("c_unlock",   N, 4'd0, 3'd5, 3'd0, 2'd3, F_PW | F_UN | F_OK);
        add("set_and_lk", S | L, 4'd0, 3'd1, 3'd0, 2'd3, F_PW);
        add_digits("re",  4'd9, 4'd8, 4'd7, 4'd6, 3'd1, 2'd3, F_PW);
        add("re_ent",     E, 4'd0, 3'd2, 3'd0, 2'd3, F_PW);
        add("p_test",     T, 4'd0, 3'd3, 3'd0, 2'd3, F_PW);
        add_digits("p",   4'd9, 4'd8, 4'd7, 4'd6, 3'd3, 2'd3, F_PW);
        add("clr_vs_ent", C | E, 4'd0, 3'd3, 3'd0, 2'd3, F_PW);
        add("q_d9",       D, 4'd9, 3'd3, 3'd1, 2'd3, F_PW);
        add("q_d8",       D, 4'd8, 3'd3, 3'd2, 2'd3, F_PW);
        add("q_d7",       D, 4'd7, 3'd3, 3'd3, 2'd3, F_PW);
        add("dig_w_ent",  D | E, 4'd6, 3'd4, 3'd3, 2'd3, F_PW);
        add("short_fail", N, 4'd0, 3'd2, 3'd0, 2'd2, F_PW | F_FAIL);
        add_try("x2", 4'd9, 4'd8, 4'd7, 4'd5, 2'd2, 2'd1, 1'b0);
        add_try("x3", 4'd0, 4'd0, 4'd0, 4'd0, 2'd1, 2'd0, 1'b1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset.state", state, 0);
        chk("reset.tries_left", tries_left, 3);
        chk("reset.digit_cnt", digit_cnt, 0);
        chk("reset.flags", flags_now(), 0);

        for (int i = 0; i < split; i++) apply(vecs[i]);

        // lockout must last exactly 8 cycles and ignore requests meanwhile
        lo_cycles = 1;
        for (int k = 0; k < 20; k++) begin
            drive((k % 2 == 0) ? T : S, 4'd0);
            if (state == 3'd6) lo_cycles++;
            else break;
        end
        chk("lockout.cycles", lo_cycles, 8);
        chk("lockout.exit_state", state, 2);
        chk("lockout.exit_tries", tries_left, 3);
        chk("lockout.exit_flags", flags_now(), F_PW);

        repeat (1100) @(posedge clk);
        #1;
        chk("perm.state", state_z, 6);
        chk("perm.locked_out", locked_out_z, 1);
        chk("idle.state", state, 2);

        for (int i = split; i < vecs.size(); i++) apply(vecs[i]);

        drive(N, 4'd0);
        chk("lock2.state", state, 6);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.state", state, 0);
        chk("async_rst.pw_set", pw_set, 0);
        chk("async_rst.locked_out", locked_out, 0);
        chk("async_rst.tries_left", tries_left, 3);
        chk("async_rst.perm_state", state_z, 0);
        chk("async_rst.perm_pw_set", pw_set_z, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(T, 4'd0);
        chk("post_rst.state", state, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/password_lock_ctrl.md
Name: password_lock_ctrl

Overview:
Parametrised digit-entry password lock controller for the board-level lock design. It collects a PW_LEN-digit password from a debounced keypad, stores it, and verifies later entries with its own comparator. It has an attempt counter and a timed lockout. It drives state and status flags for the LED/segment display logic.

Parameters:
DIGIT_W, 4, width of one keypad digit
PW_LEN, 4, digits per password (>=1)
MAX_TRIES, 3, wrong attempts allowed before lockout (>=1)
LOCK_CYCLES, 1000, lockout duration in clk cycles; 0 = permanent lockout until rst

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
set_pw  in  1  request password (re)definition, 1-cycle pulse
test  in  1  request verification, 1-cycle pulse
lock  in  1  relock from UNLOCKED, 1-cycle pulse
clear  in  1  discard digits entered so far, 1-cycle pulse
digit_valid  in  1  digit strobe, 1-cycle pulse
digit  in  DIGIT_W  digit value, sampled when digit_valid=1
enter  in  1  confirm entry, 1-cycle pulse
state  out  3  current state encoding
pw_set  out  1  a password is stored
unlocked  out  1  state==UNLOCKED
locked_out  out  1  state==LOCKOUT
pass_ok  out  1  1-cycle pulse on successful verify
pass_fail  out  1  1-cycle pulse on failed verify
entry_err  out  1  1-cycle pulse on short entry during SET_ENTRY
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
digit_cnt  out  $clog2(PW_LEN+1)  digits held in entry buffer

Behaviour:
- All inputs are synchronous, already debounced, single-cycle pulses. All outputs are registered.
- Reset (async) values:
  - state=NO_PW(0), pw_set=0, unlocked=0, locked_out=0.
  - pass_ok=0, pass_fail=0, entry_err=0.
  - tries_left=MAX_TRIES, digit_cnt=0.
  - Stored password=0, entry buffer=0, lockout counter=0.
- States and encodings: NO_PW=0, SET_ENTRY=1, READY=2, TEST_ENTRY=3, CHECK=4, UNLOCKED=5, LOCKOUT=6. Encoding 7 is illegal and goes to NO_PW.
- Entry buffer (PW_LEN*DIGIT_W bits):
  - Applies in SET_ENTRY and TEST_ENTRY only. On digit_valid with digit_cnt<PW_LEN: buffer <= {buffer[..], digit}, digit_cnt++.
  - First digit ends in the most-significant slot.
  - Digits after digit_cnt==PW_LEN are ignored. Count saturates, buffer is unchanged.
- clear in an entry state zeroes the buffer and digit_cnt.
- Same-cycle priority: clear > enter > digit_valid. A digit arriving with enter is dropped.
- Transitions:
  - NO_PW: set_pw -> SET_ENTRY. All other inputs are ignored.
  - SET_ENTRY, enter with digit_cnt==PW_LEN: stored password <= buffer, pw_set<=1, tries_left<=MAX_TRIES, -> READY.
  - SET_ENTRY, enter with digit_cnt<PW_LEN: entry_err pulse, buffer cleared, stay in SET_ENTRY.
  - READY: test -> TEST_ENTRY. set_pw is ignored, because a password change requires UNLOCKED.
  - TEST_ENTRY: enter -> CHECK, whatever digit_cnt is.
  - CHECK: lasts exactly 1 cycle and ignores all inputs. match = (digit_cnt==PW_LEN) && (buffer==stored password).
    - match: -> UNLOCKED, pass_ok=1, tries_left<=MAX_TRIES.
    - mismatch with tries_left>1: tries_left--, pass_fail=1, -> READY.
    - mismatch with tries_left==1: tries_left<=0, pass_fail=1, -> LOCKOUT.
  - UNLOCKED: set_pw -> SET_ENTRY. lock -> READY. If both arrive in the same cycle, set_pw wins.
  - LOCKOUT, LOCK_CYCLES>0: the counter loads LOCK_CYCLES-1 on entry and decrements each cycle. At 0: -> READY, tries_left<=MAX_TRIES. LOCKOUT state is therefore visible for exactly LOCK_CYCLES cycles.
  - LOCKOUT, LOCK_CYCLES==0: stays in LOCKOUT until rst.
  - All inputs are ignored during LOCKOUT.
- The buffer and digit_cnt clear on every entry into SET_ENTRY or TEST_ENTRY, and on leaving CHECK.
- pass_ok, pass_fail and entry_err are high for exactly 1 cycle. pass_ok/pass_fail coincide with the first cycle of the state following CHECK.
- Latency: enter -> CHECK on the next edge -> result state and pulse on the edge after. Total is 2 cycles.
- Reset mid-operation (any state, including LOCKOUT) loses the stored password. pw_set returns to 0.

Test Plan:
1. Assert and release rst -> state=0, tries_left=3, digit_cnt=0, all flags 0. digit, enter and test in NO_PW leave state=0.
2. set_pw, digits 1,2,3,4, enter -> pw_set=1, state=2, digit_cnt=0. Repeat with only 1,2 then enter -> entry_err single pulse, state stays 1.
3. From READY: test, digits 1,2,3,4,5, enter -> digit_cnt saturates at 4, 5th digit ignored. Exactly 1 cycle in state 4, then state=5 with unlocked=1 and a single-cycle pass_ok.
4. Three wrong tries (1,2,3,5) with LOCK_CYCLES=8 -> pass_fail pulses, tries_left 2, 1, 0. After the 3rd: state=6, locked_out=1 for exactly 8 cycles, then state=2, tries_left=3.
5. In UNLOCKED: set_pw, enter 9,8,7,6, lock, test with 1,2,3,4 -> pass_fail. test with 9,8,7,6 -> pass_ok. clear mid-entry drops the digits.
6. Async rst asserted mid-LOCKOUT between clock edges -> state=0 and pw_set=0 immediately. With LOCK_CYCLES=0, LOCKOUT persists for more than 1000 cycles until rst.
